// File: rtl/decode_pkg.sv
// Shared decode definitions: opcodes, func7 patterns, memory access types, control bundle.
// No logic, constants and types only.
// Not applicable: no flow control in a package.
package decode_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    STORE_NONE = 2'b00,
    STORE_SB   = 2'b01,
    STORE_SH   = 2'b10,
    STORE_SW   = 2'b11
  } store_type_e;

  typedef enum logic [2:0] {
    LOAD_LB   = 3'b000,
    LOAD_LH   = 3'b001,
    LOAD_LW   = 3'b010,
    LOAD_LBU  = 3'b011,
    LOAD_LHU  = 3'b100,
    LOAD_NONE = 3'b111
  } load_type_e;

  typedef struct packed {
    logic        alu_src;
    logic        mem_write;
    logic        mem_read;
    logic        wb_reg_file;
    logic        invalid_inst;
    load_type_e  load_type;
    store_type_e store_type;
  } ctrl_t;

  // Bundle for an empty slot: nothing happens downstream.
  localparam ctrl_t CTRL_BUBBLE = '{
    alu_src: 1'b0, mem_write: 1'b0, mem_read: 1'b0, wb_reg_file: 1'b0,
    invalid_inst: 1'b0, load_type: LOAD_NONE, store_type: STORE_NONE
  };

  // Bundle for an undecodable instruction: side-effect free, but flagged.
  localparam ctrl_t CTRL_INVALID = '{
    alu_src: 1'b0, mem_write: 1'b0, mem_read: 1'b0, wb_reg_file: 1'b0,
    invalid_inst: 1'b1, load_type: LOAD_NONE, store_type: STORE_NONE
  };

endpackage

// File: rtl/decode_controller.sv
// Combinational instruction decoder producing the control bundle and source-register usage.
// Latency: zero cycles, pure combinational.
// No backpressure: output follows the instruction fields every cycle.
module decode_controller
  import decode_pkg::*;
#(
  parameter bit SUPPORT_M = 1'b0
) (
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  output ctrl_t      ctrl,
  output logic       use_rs1,
  output logic       use_rs2
);

  logic bad;

  // Opcode/func decode; any unrecognised encoding collapses to the invalid bundle at the end.
  always_comb begin
    ctrl    = CTRL_BUBBLE;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    bad     = 1'b0;
    case (opcode)
      OP_R: begin
        use_rs1          = 1'b1;
        use_rs2          = 1'b1;
        ctrl.wb_reg_file = 1'b1;
        if (!((func7 == F7_BASE) ||
              ((func7 == F7_ALT) && ((func3 == 3'b000) || (func3 == 3'b101))) ||
              (SUPPORT_M && (func7 == F7_MULDIV)))) begin
          bad = 1'b1;
        end
      end
      OP_IMM: begin
        use_rs1          = 1'b1;
        ctrl.alu_src     = 1'b1;
        ctrl.wb_reg_file = 1'b1;
      end
      OP_LOAD: begin
        use_rs1          = 1'b1;
        ctrl.alu_src     = 1'b1;
        ctrl.mem_read    = 1'b1;
        ctrl.wb_reg_file = 1'b1;
        case (func3)
          3'b000:  ctrl.load_type = LOAD_LB;
          3'b001:  ctrl.load_type = LOAD_LH;
          3'b010:  ctrl.load_type = LOAD_LW;
          3'b100:  ctrl.load_type = LOAD_LBU;
          3'b101:  ctrl.load_type = LOAD_LHU;
          default: bad = 1'b1;
        endcase
      end
      OP_STORE: begin
        use_rs1        = 1'b1;
        use_rs2        = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
        case (func3)
          3'b000:  ctrl.store_type = STORE_SB;
          3'b001:  ctrl.store_type = STORE_SH;
          3'b010:  ctrl.store_type = STORE_SW;
          default: bad = 1'b1;
        endcase
      end
      OP_BRANCH: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OP_JAL: begin
        ctrl.wb_reg_file = 1'b1;
      end
      OP_JALR: begin
        use_rs1          = 1'b1;
        ctrl.alu_src     = 1'b1;
        ctrl.wb_reg_file = 1'b1;
      end
      OP_AUIPC, OP_LUI: begin
        ctrl.alu_src     = 1'b1;
        ctrl.wb_reg_file = 1'b1;
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      ctrl = CTRL_INVALID;
    end
  end

endmodule

// File: rtl/decode_pipe_ctrl.sv
// ID->EX control stage: decode, load-use hazard bubble, EX control register, invalid counter.
// Latency: one cycle from ID instruction to EX outputs.
// Backpressure: id_stall holds ID on hazard or ex_stall; ex_flush overrides both and kills EX.
module decode_pipe_ctrl
  import decode_pkg::*;
#(
  parameter bit SUPPORT_M = 1'b0,
  parameter bit HAZARD_EN = 1'b1,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [31:0]      id_instr,
  input  logic             ex_stall,
  input  logic             ex_flush,
  output logic             id_stall,
  output logic             ex_valid,
  output logic             ex_alu_src,
  output logic             ex_mem_write,
  output logic             ex_mem_read,
  output logic             ex_wb_reg_file,
  output logic             ex_invalid_inst,
  output logic [2:0]       ex_mem_load_type,
  output logic [1:0]       ex_mem_store_type,
  output logic [4:0]       ex_rd,
  output logic [CNT_W-1:0] invalid_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  ctrl_t            id_ctrl;
  logic             use_rs1;
  logic             use_rs2;
  logic [4:0]       id_rd;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             hazard;
  logic             load_id;

  ctrl_t            ex_ctrl_q;
  logic             ex_valid_q;
  logic [4:0]       ex_rd_q;
  logic [CNT_W-1:0] cnt_q;

  assign id_rd  = id_instr[11:7];
  assign id_rs1 = id_instr[19:15];
  assign id_rs2 = id_instr[24:20];

  decode_controller #(
    .SUPPORT_M (SUPPORT_M)
  ) u_decode (
    .opcode  (id_instr[6:0]),
    .func3   (id_instr[14:12]),
    .func7   (id_instr[31:25]),
    .ctrl    (id_ctrl),
    .use_rs1 (use_rs1),
    .use_rs2 (use_rs2)
  );

  // Load-use hazard: the load in EX produces a register the ID instruction reads.
  always_comb begin
    hazard = 1'b0;
    if (HAZARD_EN && ex_valid_q && ex_ctrl_q.mem_read && (ex_rd_q != 5'd0) && id_valid) begin
      hazard = (use_rs1 && (id_rs1 == ex_rd_q)) || (use_rs2 && (id_rs2 == ex_rd_q));
    end
  end

  assign id_stall = (hazard | ex_stall) & ~ex_flush;

  // ID contents are accepted into EX only when no flush, hold or hazard bubble wins.
  assign load_id = ~ex_flush & ~ex_stall & ~hazard & id_valid;

  // EX register: reset > flush bubble > hold > hazard bubble > load (empty ID loads a bubble).
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q <= 1'b0;
      ex_ctrl_q  <= CTRL_BUBBLE;
      ex_rd_q    <= 5'd0;
    end else if (ex_flush) begin
      ex_valid_q <= 1'b0;
      ex_ctrl_q  <= CTRL_BUBBLE;
      ex_rd_q    <= 5'd0;
    end else if (ex_stall) begin
      ex_valid_q <= ex_valid_q;
      ex_ctrl_q  <= ex_ctrl_q;
      ex_rd_q    <= ex_rd_q;
    end else if (load_id) begin
      ex_valid_q <= 1'b1;
      ex_ctrl_q  <= id_ctrl;
      ex_rd_q    <= id_rd;
    end else begin
      ex_valid_q <= 1'b0;
      ex_ctrl_q  <= CTRL_BUBBLE;
      ex_rd_q    <= 5'd0;
    end
  end

  // Saturating count of invalid instructions actually entering EX.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_id && id_ctrl.invalid_inst && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign ex_valid          = ex_valid_q;
  assign ex_alu_src        = ex_ctrl_q.alu_src;
  assign ex_mem_write      = ex_ctrl_q.mem_write;
  assign ex_mem_read       = ex_ctrl_q.mem_read;
  assign ex_wb_reg_file    = ex_ctrl_q.wb_reg_file;
  assign ex_invalid_inst   = ex_ctrl_q.invalid_inst;
  assign ex_mem_load_type  = ex_ctrl_q.load_type;
  assign ex_mem_store_type = ex_ctrl_q.store_type;
  assign ex_rd             = ex_rd_q;
  assign invalid_cnt       = cnt_q;

endmodule

// File: tb/tb_decode_pipe_ctrl.sv
// Bench for decode_pipe_ctrl: two instances (M off/hazard on/8-bit count, M on/hazard off/2-bit count).
// Directed table, hand sequences for stall/flush/hazard/saturation, then random against a model.
// Inputs shared by both instances.
module tb_decode_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [31:0] id_instr;
  logic        ex_stall;
  logic        ex_flush;

  logic       a_stall, a_valid, a_alu, a_mw, a_mr, a_wb, a_inv;
  logic [2:0] a_ld;
  logic [1:0] a_st;
  logic [4:0] a_rd;
  logic [7:0] a_cnt;

  logic       b_stall, b_valid, b_alu, b_mw, b_mr, b_wb, b_inv;
  logic [2:0] b_ld;
  logic [1:0] b_st;
  logic [4:0] b_rd;
  logic [1:0] b_cnt;

  always #5 clk = ~clk;

  decode_pipe_ctrl #(.SUPPORT_M(1'b0), .HAZARD_EN(1'b1), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr),
    .ex_stall(ex_stall), .ex_flush(ex_flush), .id_stall(a_stall),
    .ex_valid(a_valid), .ex_alu_src(a_alu), .ex_mem_write(a_mw), .ex_mem_read(a_mr),
    .ex_wb_reg_file(a_wb), .ex_invalid_inst(a_inv), .ex_mem_load_type(a_ld),
    .ex_mem_store_type(a_st), .ex_rd(a_rd), .invalid_cnt(a_cnt)
  );

  decode_pipe_ctrl #(.SUPPORT_M(1'b1), .HAZARD_EN(1'b0), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr),
    .ex_stall(ex_stall), .ex_flush(ex_flush), .id_stall(b_stall),
    .ex_valid(b_valid), .ex_alu_src(b_alu), .ex_mem_write(b_mw), .ex_mem_read(b_mr),
    .ex_wb_reg_file(b_wb), .ex_invalid_inst(b_inv), .ex_mem_load_type(b_ld),
    .ex_mem_store_type(b_st), .ex_rd(b_rd), .invalid_cnt(b_cnt)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // EX bundle packed as {valid, alu_src, mem_write, mem_read, wb, invalid, load[2:0], store[1:0], rd[4:0]}
  function automatic logic [15:0] a_bus();
    return {a_valid, a_alu, a_mw, a_mr, a_wb, a_inv, a_ld, a_st, a_rd};
  endfunction

  function automatic logic [15:0] b_bus();
    return {b_valid, b_alu, b_mw, b_mr, b_wb, b_inv, b_ld, b_st, b_rd};
  endfunction

  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [4:0] rs2,
                                     input logic [4:0] rs1, input logic [2:0] f3,
                                     input logic [4:0] rd, input logic [6:0] op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction

  // ---------------- reference model ----------------
  typedef struct {
    logic [6:0] op;
    bit alu, mw, mr, wb, u1, u2;
  } opinfo_t;

  typedef struct {
    bit alu, mw, mr, wb, inv, u1, u2;
    logic [2:0] ld;
    logic [1:0] st;
  } dec_t;

  typedef struct {
    bit valid, alu, mw, mr, wb, inv;
    logic [2:0] ld;
    logic [1:0] st;
    logic [4:0] rd;
    int cnt;
  } mstate_t;

  opinfo_t ops[9];

  function automatic dec_t model_decode(input logic [31:0] ins, input bit sm);
    dec_t d;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    bit ok;
    op = ins[6:0];
    f3 = ins[14:12];
    f7 = ins[31:25];
    d = '{default: 0};
    d.ld = 3'b111;
    d.st = 2'b00;
    ok = 0;
    foreach (ops[i]) begin
      if (ops[i].op == op) begin
        ok = 1;
        d.alu = ops[i].alu; d.mw = ops[i].mw; d.mr = ops[i].mr;
        d.wb = ops[i].wb; d.u1 = ops[i].u1; d.u2 = ops[i].u2;
      end
    end
    if (op == 7'b0110011)
      ok = (f7 == 7'h00) || ((f7 == 7'h20) && (f3 == 3'd0 || f3 == 3'd5)) || (sm && f7 == 7'h01);
    if (op == 7'b0000011) begin
      ok = (f3 != 3'd3) && (f3 <= 3'd5);
      if (ok) d.ld = (f3 >= 3'd4) ? f3 - 3'd1 : f3;
    end
    if (op == 7'b0100011) begin
      ok = (f3 < 3'd3);
      if (ok) d.st = f3[1:0] + 2'd1;
    end
    if (!ok) begin
      d.alu = 0; d.mw = 0; d.mr = 0; d.wb = 0;
      d.ld = 3'b111; d.st = 2'b00;
    end
    d.inv = !ok;
    return d;
  endfunction

  function automatic mstate_t m_reset();
    mstate_t m;
    m = '{default: 0};
    m.ld = 3'b111;
    return m;
  endfunction

  function automatic bit m_hazard(input mstate_t m, input bit he, input logic idv,
                                  input logic [31:0] ins);
    dec_t d;
    d = model_decode(ins, 1'b0);
    if (!(he && m.valid && m.mr && m.rd != 0 && idv)) return 0;
    return (d.u1 && ins[19:15] == m.rd) || (d.u2 && ins[24:20] == m.rd);
  endfunction

  function automatic bit m_stall(input mstate_t m, input bit he, input logic idv,
                                 input logic [31:0] ins, input logic st, input logic fl);
    return (m_hazard(m, he, idv, ins) || st) && !fl;
  endfunction

  function automatic mstate_t m_next(input mstate_t m, input bit sm, input bit he, input int cmax,
                                     input logic r, input logic idv, input logic [31:0] ins,
                                     input logic st, input logic fl);
    mstate_t n;
    dec_t d;
    d = model_decode(ins, sm);
    if (r) return m_reset();
    n = m_reset();
    n.cnt = m.cnt;
    if (fl) return n;
    if (st) return m;
    if (m_hazard(m, he, idv, ins)) return n;
    if (!idv) return n;
    n.valid = 1; n.alu = d.alu; n.mw = d.mw; n.mr = d.mr; n.wb = d.wb; n.inv = d.inv;
    n.ld = d.ld; n.st = d.st; n.rd = ins[11:7];
    if (d.inv && n.cnt < cmax) n.cnt = n.cnt + 1;
    return n;
  endfunction

  function automatic logic [15:0] m_bus(input mstate_t m);
    return {m.valid, m.alu, m.mw, m.mr, m.wb, m.inv, m.ld, m.st, m.rd};
  endfunction

  // ---------------- directed table ----------------
  typedef struct {
    logic [31:0] instr;
    logic [4:0]  bits;   // {alu_src, mem_write, mem_read, wb, invalid} for the SUPPORT_M=0 instance
    logic [2:0]  ld;
    logic [1:0]  st;
    logic        inv_b;  // invalid flag expected from the SUPPORT_M=1 instance
  } vec_t;

  vec_t vecs[24];

  task automatic do_reset();
    rst = 1'b1; id_valid = 1'b0; ex_stall = 1'b0; ex_flush = 1'b0; id_instr = 32'h0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, tests=%0d", tests);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] tmp;
    logic [31:0] add_i;
    logic [15:0] held;
    logic [15:0] rst_bus;
    int exp_cnt_a;
    int exp_cnt_b;
    mstate_t ma, mb, na, nb;

    ops[0] = '{7'b0110011, 0, 0, 0, 1, 1, 1};
    ops[1] = '{7'b0010011, 1, 0, 0, 1, 1, 0};
    ops[2] = '{7'b0000011, 1, 0, 1, 1, 1, 0};
    ops[3] = '{7'b0100011, 1, 1, 0, 0, 1, 1};
    ops[4] = '{7'b1100011, 0, 0, 0, 0, 1, 1};
    ops[5] = '{7'b1101111, 0, 0, 0, 1, 0, 0};
    ops[6] = '{7'b1100111, 1, 0, 0, 1, 1, 0};
    ops[7] = '{7'b0010111, 1, 0, 0, 1, 0, 0};
    ops[8] = '{7'b0110111, 1, 0, 0, 1, 0, 0};

    vecs[0]  = '{mk(7'h00, 5'd2, 5'd1, 3'd0, 5'd3,  7'b0110011), 5'b00010, 3'd7, 2'd0, 1'b0};
    vecs[1]  = '{mk(7'h20, 5'd2, 5'd1, 3'd0, 5'd4,  7'b0110011), 5'b00010, 3'd7, 2'd0, 1'b0};
    vecs[2]  = '{mk(7'h20, 5'd2, 5'd1, 3'd5, 5'd5,  7'b0110011), 5'b00010, 3'd7, 2'd0, 1'b0};
    vecs[3]  = '{mk(7'h20, 5'd2, 5'd1, 3'd1, 5'd6,  7'b0110011), 5'b00001, 3'd7, 2'd0, 1'b1};
    vecs[4]  = '{mk(7'h01, 5'd2, 5'd1, 3'd0, 5'd7,  7'b0110011), 5'b00001, 3'd7, 2'd0, 1'b0};
    vecs[5]  = '{mk(7'h7F, 5'd2, 5'd1, 3'd0, 5'd8,  7'b0110011), 5'b00001, 3'd7, 2'd0, 1'b1};
    vecs[6]  = '{mk(7'h05, 5'd3, 5'd1, 3'd0, 5'd9,  7'b0010011), 5'b10010, 3'd7, 2'd0, 1'b0};
    vecs[7]  = '{mk(7'h00, 5'd0, 5'd1, 3'd0, 5'd10, 7'b0000011), 5'b10110, 3'd0, 2'd0, 1'b0};
    vecs[8]  = '{mk(7'h00, 5'd0, 5'd1, 3'd1, 5'd11, 7'b0000011), 5'b10110, 3'd1, 2'd0, 1'b0};
    vecs[9]  = '{mk(7'h00, 5'd0, 5'd1, 3'd2, 5'd12, 7'b0000011), 5'b10110, 3'd2, 2'd0, 1'b0};
    vecs[10] = '{mk(7'h00, 5'd0, 5'd1, 3'd4, 5'd13, 7'b0000011), 5'b10110, 3'd3, 2'd0, 1'b0};
    vecs[11] = '{mk(7'h00, 5'd0, 5'd1, 3'd5, 5'd14, 7'b0000011), 5'b10110, 3'd4, 2'd0, 1'b0};
    vecs[12] = '{mk(7'h00, 5'd0, 5'd1, 3'd3, 5'd15, 7'b0000011), 5'b00001, 3'd7, 2'd0, 1'b1};
    vecs[13] = '{mk(7'h00, 5'd0, 5'd1, 3'd7, 5'd16, 7'b0000011), 5'b00001, 3'd7, 2'd0, 1'b1};
    vecs[14] = '{mk(7'h00, 5'd2, 5'd1, 3'd0, 5'd1,  7'b0100011), 5'b11000, 3'd7, 2'd1, 1'b0};
    vecs[15] = '{mk(7'h00, 5'd2, 5'd1, 3'd1, 5'd2,  7'b0100011), 5'b11000, 3'd7, 2'd2, 1'b0};
    vecs[16] = '{mk(7'h00, 5'd2, 5'd1, 3'd2, 5'd3,  7'b0100011), 5'b11000, 3'd7, 2'd3, 1'b0};
    vecs[17] = '{mk(7'h00, 5'd2, 5'd1, 3'd3, 5'd4,  7'b0100011), 5'b00001, 3'd7, 2'd0, 1'b1};
    vecs[18] = '{mk(7'h00, 5'd2, 5'd1, 3'd0, 5'd8,  7'b1100011), 5'b00000, 3'd7, 2'd0, 1'b0};
    vecs[19] = '{mk(7'h12, 5'd3, 5'd4, 3'd5, 5'd17, 7'b1101111), 5'b00010, 3'd7, 2'd0, 1'b0};
    vecs[20] = '{mk(7'h00, 5'd0, 5'd1, 3'd0, 5'd18, 7'b1100111), 5'b10010, 3'd7, 2'd0, 1'b0};
    vecs[21] = '{mk(7'h11, 5'd9, 5'd9, 3'd1, 5'd19, 7'b0010111), 5'b10010, 3'd7, 2'd0, 1'b0};
    vecs[22] = '{mk(7'h22, 5'd8, 5'd7, 3'd6, 5'd20, 7'b0110111), 5'b10010, 3'd7, 2'd0, 1'b0};
    vecs[23] = '{mk(7'h00, 5'd0, 5'd0, 3'd0, 5'd21, 7'b1111111), 5'b00001, 3'd7, 2'd0, 1'b1};

    rst_bus = {1'b0, 5'b00000, 3'b111, 2'b00, 5'd0};

    // Reset state
    do_reset();
    check("reset bus a", a_bus(), rst_bus);
    check("reset bus b", b_bus(), rst_bus);
    check("reset cnt a", a_cnt, 0);
    check("reset cnt b", b_cnt, 0);
    check("reset stall a", a_stall, 0);

    // Directed decode table, each vector separated by an idle cycle
    exp_cnt_a = 0;
    exp_cnt_b = 0;
    for (int i = 0; i < 24; i++) begin
      id_valid = 1'b1;
      id_instr = vecs[i].instr;
      @(posedge clk); #1;
      id_valid = 1'b0;
      tmp = vecs[i].instr;
      exp_cnt_a += vecs[i].bits[0] ? 1 : 0;
      if (vecs[i].inv_b && exp_cnt_b < 3) exp_cnt_b++;
      check($sformatf("vec%0d bus a", i), a_bus(), {1'b1, vecs[i].bits, vecs[i].ld, vecs[i].st, tmp[11:7]});
      check($sformatf("vec%0d inv b", i), b_inv, vecs[i].inv_b);
      check($sformatf("vec%0d cnt a", i), a_cnt, exp_cnt_a);
      check($sformatf("vec%0d cnt b", i), b_cnt, exp_cnt_b);
      @(posedge clk); #1;
    end

    // Load-use: lw x5 then add x6,x5,x1
    do_reset();
    add_i = mk(7'h00, 5'd1, 5'd5, 3'd0, 5'd6, 7'b0110011);
    id_valid = 1'b1;
    id_instr = 32'h0002A283;
    @(posedge clk); #1;
    id_instr = add_i;
    check("lu stall a", a_stall, 1);
    check("lu stall b (hazard off)", b_stall, 0);
    @(posedge clk); #1;
    check("lu bubble a valid", a_valid, 0);
    check("lu stall a released", a_stall, 0);
    check("lu add in ex b", b_bus(), {1'b1, 5'b00010, 3'b111, 2'b00, 5'd6});
    @(posedge clk); #1;
    check("lu add in ex a", a_bus(), {1'b1, 5'b00010, 3'b111, 2'b00, 5'd6});
    id_valid = 1'b0;

    // ex_stall hold for 3 cycles with changing ID, then flush while stalled
    do_reset();
    id_valid = 1'b1;
    id_instr = mk(7'h00, 5'd2, 5'd3, 3'd0, 5'd7, 7'b0110011);
    @(posedge clk); #1;
    held = {1'b1, 5'b00010, 3'b111, 2'b00, 5'd7};
    ex_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      id_instr = mk(7'h00, 5'(k), 5'(k + 1), 3'd2, 5'(20 + k), 7'b0000011);
      @(posedge clk); #1;
      check($sformatf("hold%0d bus a", k), a_bus(), held);
      check($sformatf("hold%0d stall a", k), a_stall, 1);
    end
    ex_flush = 1'b1;
    #1;
    check("flush stall a", a_stall, 0);
    check("flush stall b", b_stall, 0);
    @(posedge clk); #1;
    check("flush bubble a", a_bus(), rst_bus);
    check("flush bubble b", b_valid, 0);
    ex_flush = 1'b0;
    ex_stall = 1'b0;

    // Counter saturation on the 2-bit instance, then reset mid-sequence
    do_reset();
    id_valid = 1'b1;
    id_instr = mk(7'h00, 5'd0, 5'd0, 3'd0, 5'd1, 7'b1111111);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check($sformatf("sat%0d cnt b", k), b_cnt, (k + 1 > 3) ? 3 : k + 1);
      check($sformatf("sat%0d cnt a", k), a_cnt, k + 1);
    end
    rst = 1'b1;
    ex_stall = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst bus a", a_bus(), rst_bus);
    check("midrst bus b", b_bus(), rst_bus);
    check("midrst cnt a", a_cnt, 0);
    check("midrst cnt b", b_cnt, 0);
    ex_stall = 1'b0;

    // Randomised traffic against the model
    do_reset();
    ma = m_reset();
    mb = m_reset();
    for (int n = 0; n < 500; n++) begin
      logic [6:0] op;
      logic [6:0] f7;
      int sel;
      sel = $urandom_range(0, 10);
      if (sel < 9) op = ops[sel].op;
      else if (sel == 9) op = 7'b1111111;
      else op = 7'($urandom);
      case ($urandom_range(0, 3))
        0: f7 = 7'h00;
        1: f7 = 7'h20;
        2: f7 = 7'h01;
        default: f7 = 7'($urandom);
      endcase
      id_instr = mk(f7, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    3'($urandom), 5'($urandom_range(0, 3)), op);
      id_valid = ($urandom_range(0, 9) < 8);
      ex_stall = ($urandom_range(0, 99) < 15);
      ex_flush = ($urandom_range(0, 99) < 8);
      rst      = ($urandom_range(0, 99) < 2);
      @(negedge clk);
      check($sformatf("rnd%0d stall a", n), a_stall, m_stall(ma, 1'b1, id_valid, id_instr, ex_stall, ex_flush));
      check($sformatf("rnd%0d stall b", n), b_stall, m_stall(mb, 1'b0, id_valid, id_instr, ex_stall, ex_flush));
      check($sformatf("rnd%0d bus a", n), a_bus(), m_bus(ma));
      check($sformatf("rnd%0d bus b", n), b_bus(), m_bus(mb));
      check($sformatf("rnd%0d cnt a", n), a_cnt, ma.cnt);
      check($sformatf("rnd%0d cnt b", n), b_cnt, mb.cnt);
      na = m_next(ma, 1'b0, 1'b1, 255, rst, id_valid, id_instr, ex_stall, ex_flush);
      nb = m_next(mb, 1'b1, 1'b0, 3, rst, id_valid, id_instr, ex_stall, ex_flush);
      @(posedge clk); #1;
      ma = na;
      mb = nb;
    end
    rst = 1'b0; id_valid = 1'b0; ex_stall = 1'b0; ex_flush = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/decode_pipe_ctrl.md
DECODE_PIPE_CTRL -- requirements
Module: decode_pipe_ctrl

Interface
REQ-001 SUPPORT_M, 0, when 1 the R-type encoding with func7=0000001 (RV32M) is decoded as valid.
REQ-002 HAZARD_EN, 1, when 1 load-use hazard detection and bubble insertion are enabled; when 0 no hazard stall is generated.
REQ-003 CNT_W, 8, width of the invalid-instruction counter.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 id_valid  in  1  ID stage holds a real instruction.
REQ-007 id_instr  in  32  ID instruction; opcode [6:0], rd [11:7], func3 [14:12], rs1 [19:15], rs2 [24:20], func7 [31:25].
REQ-008 ex_stall  in  1  downstream hold request; the EX register keeps its contents.
REQ-009 ex_flush  in  1  kill request; the EX register becomes a bubble.
REQ-010 id_stall  out  1  combinational; ID must hold its instruction this cycle.
REQ-011 ex_valid, ex_alu_src, ex_mem_write, ex_mem_read, ex_wb_reg_file, ex_invalid_inst  out  1 each  registered control bundle.
REQ-012 ex_mem_load_type  out  3, ex_mem_store_type  out  2, ex_rd  out  5  registered.
REQ-013 invalid_cnt  out  CNT_W  saturating count of invalid instructions accepted into EX.

Function
REQ-014 Decode SHALL be combinational from id_instr: R 0110011 (wb); I-ALU 0010011 (alu_src, wb); load 0000011 (alu_src, mem_read, wb); store 0100011 (alu_src, mem_write); branch 1100011 (no wb, no alu_src); JAL 1101111 (wb); JALR 1100111 (alu_src, wb); AUIPC 0010111 and LUI 0110111 (alu_src, wb).
REQ-015 R-type SHALL be valid only for func7 0000000 (any func3), func7 0100000 with func3 000 or 101, or func7 0000001 when SUPPORT_M=1; any other R-type func7/func3 combination is invalid.
REQ-016 Store type SHALL decode as func3 000->STORE_SB, 001->STORE_SH, 010->STORE_SW; any other func3 is invalid.
REQ-017 Load type SHALL decode as func3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; any other func3 is invalid.
REQ-018 Any unlisted opcode SHALL be invalid.
REQ-019 An invalid instruction SHALL clear every control bit to 0, set ex_invalid_inst=1, set mem types to NONE, and still set ex_valid=1.
REQ-020 A hazard SHALL exist when HAZARD_EN=1, ex_valid=1, ex_mem_read=1, ex_rd!=0, id_valid=1, and ex_rd equals a source the ID instruction uses: rs1 for R, I-ALU, load, store, branch and JALR; rs2 for R, store and branch.
REQ-021 id_stall SHALL equal (hazard | ex_stall) & ~ex_flush.
REQ-022 EX register update priority per edge: rst > ex_flush (bubble) > ex_stall (hold) > hazard (bubble) > load decoded ID contents (ex_valid=id_valid).
REQ-023 A bubble SHALL set ex_valid=0, all control bits 0, mem types NONE, and ex_rd=0.
REQ-024 When id_valid=0, the stage SHALL load a bubble.
REQ-025 Latency SHALL be one cycle, ID to EX outputs.
REQ-026 invalid_cnt SHALL increment only when a valid invalid instruction is loaded (not on hold, bubble or flush), and SHALL saturate at 2^CNT_W-1.

Reset
REQ-027 On rst=1 at a rising edge, every registered output and invalid_cnt SHALL become 0, and mem types SHALL become NONE.
REQ-028 rst SHALL override simultaneous ex_flush, ex_stall and hazard.

Structure
REQ-029 A shared package decode_pkg SHALL hold the opcode constants, func7 constants, STORE_NONE/SB/SH/SW = 00/01/10/11 and LOAD_LB/LH/LW/LBU/LHU/NONE = 000/001/010/011/100/111.
REQ-030 The combinational decoder SHALL be the sub-module decode_controller, which is parametrised by SUPPORT_M; hazard logic, the EX register and the counter stay in the top module.

Verification
REQ-031 Load x5 (0x0002A283 class, rd=5) followed by add x6,x5,x1 -> id_stall=1 for exactly one cycle, one bubble (ex_valid=0), then the add appears in EX.
REQ-032 Same sequence with HAZARD_EN=0 -> id_stall=0 and the add enters EX the cycle after the load.
REQ-033 R-type func7=0000001 -> ex_invalid_inst=0 when SUPPORT_M=1, and =1 with invalid_cnt+1 when SUPPORT_M=0.
REQ-034 Store with func3=000/001/010/011 -> ex_mem_store_type 01/10/11, then ex_invalid_inst=1.
REQ-035 ex_stall held 3 cycles while ID changes -> EX contents unchanged; simultaneous ex_flush -> bubble next cycle and id_stall=0.
REQ-036 CNT_W=2 with 5 consecutive opcode 1111111 instructions -> invalid_cnt 1,2,3,3,3; rst mid-sequence -> all outputs 0 on the next edge.
